gpu_palette_clut: RTL and testbench
===================================

Name: gpu_palette_clut

Overview:
Parametrised colour lookup table for the graphics GPU. It is the successor to the fixed 16-entry RGB444 palette. Depth and component width are configurable. CPU programming uses a VGA-DAC style sequenced port: load an index, then write R, G, B with auto-increment, and each entry commits atomically. Pixel lookup is a registered 2-stage pipeline with valid tracking that feeds the DVI output stage.

Parameters:
INDEX_W, 4, palette index width; the palette has 2^INDEX_W entries.
COMP_W, 4, stored bits per colour component (1..8).
OUT_W, 8, output bits per component; must be >= COMP_W.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
wr_addr_we  input  1  load the write index and clear the write phase
wr_addr  input  INDEX_W  write index value
wr_data_we  input  1  write one component at the current write phase
wr_data  input  COMP_W  component value
rd_addr_we  input  1  load the readback index and clear the read phase
rd_addr  input  INDEX_W  readback index value
rd_data_re  input  1  read one component at the current read phase
rd_data  output  COMP_W  readback component, registered
pix_valid_in  input  1  pixel index valid
pix_index  input  INDEX_W  pixel palette index
pix_valid_out  output  1  expanded colour valid
rgb_r  output  OUT_W  red, expanded
rgb_g  output  OUT_W  green, expanded
rgb_b  output  OUT_W  blue, expanded

Behaviour:
- Clock and reset: clock clk; reset rst_n, synchronous, active-low.
- Reset effects:
  - wr_idx=0, wr_phase=R, staged R/G=0.
  - rd_idx=0, rd_phase=R, rd_data=0.
  - Pipeline valids=0; pix_valid_out=0; rgb_* = 0.
  - Every entry i is loaded with a grayscale ramp: each component = EXP_COMP(i).
- Expansion functions:
  - EXP(x, W): replicate x MSB-first and truncate to W bits. Example: COMP_W=4, OUT_W=8, 0xA -> 0xAA. Example: COMP_W=3, 101 -> 10110110.
  - EXP_COMP(i) = EXP(i, COMP_W) when INDEX_W < COMP_W; otherwise the top COMP_W bits of i.
- Write sequencer: FSM with states R -> G -> B.
  - State R: wr_data_we stages R and moves to G.
  - State G: wr_data_we stages G and moves to B.
  - State B: wr_data_we writes {staged R, staged G, wr_data} to entry wr_idx in one cycle, then returns to R with wr_idx = wr_idx+1. At 2^INDEX_W-1 the index wraps to 0.
  - A partial sequence (R or G staged only) never modifies the array.
- Write priority: wr_addr_we has priority. A wr_data_we in the same cycle is discarded. Phase returns to R and the staged values are dropped.
- Pixel pipeline, latency 2 cycles:
  - Stage 1 registers the array read of pix_index, plus valid.
  - Stage 2 registers the EXP(.,OUT_W) results, plus valid.
  - rgb_* hold their value when pix_valid_out=0.
  - Throughput is 1 pixel per cycle with no stalls.
- Write/read collision: if an entry commit and a stage-1 read of the same index occur in the same cycle, the lookup returns the OLD value. The new value is visible to reads from the next cycle.
- Reset mid-operation: the sequence is aborted, the pipeline is flushed (pix_valid_out=0 on the cycle after reset is sampled), and the array is reinitialised to the ramp.

Optional Feature:
Macro GPU_PALETTE_READBACK_EN.
- Defined:
  - rd_data_re returns the component of entry rd_idx at rd_phase on rd_data, 1 cycle later.
  - Phase advances R -> G -> B. After B, rd_idx increments with wrap.
  - rd_addr_we has priority over rd_data_re and resets the phase to R.
  - Readback never disturbs the write sequencer or the pixel path.
- Undefined: rd_data is tied to 0, and rd_addr_we and rd_data_re are ignored. No readback logic or state is synthesised.

Test Plan:
- Reset, defaults (INDEX_W=4, COMP_W=4, OUT_W=8) -> pix_index=5 with valid gives rgb=0x55/0x55/0x55 exactly 2 cycles later; index 15 gives 0xFF.
- Auto-increment and wrap -> wr_addr=15, then write A,3,C and 1,2,7 -> entry 15 = AA/33/CC and entry 0 = 11/22/77; entry 1 unchanged.
- Atomic commit -> write R=F, G=F to entry 2, then assert wr_addr_we=2 together with wr_data_we -> entry 2 stays 0x22 grey; the next R/G/B sequence writes entry 2 fresh.
- Collision -> commit entry 4 = 0/0/0 in the same cycle pix_index=4 enters stage 1 -> output 0x44 grey; a lookup the next cycle gives 0x00.
- Back-to-back pixels 0..15 every cycle -> pix_valid_out high for 16 cycles, ramp output in order, no bubbles; assert reset mid-stream -> valid drops to 0.
- (GPU_PALETTE_READBACK_EN) rd_addr=15, then six rd_data_re -> returns entry-15 R, G, B, then entry-0 R, G, B, matching the written values.

Source files
------------

// File: rtl/gpu_palette_clut_if.sv
// Bus bundle for the palette CLUT: CPU write/readback port plus the pixel lookup path.
// The master modport is the CPU/pixel source side, the slave modport is the CLUT itself.
interface gpu_palette_clut_if #(
  parameter int INDEX_W = 4,
  parameter int COMP_W  = 4,
  parameter int OUT_W   = 8
);
  logic               wr_addr_we;
  logic [INDEX_W-1:0] wr_addr;
  logic               wr_data_we;
  logic [COMP_W-1:0]  wr_data;
  logic               rd_addr_we;
  logic [INDEX_W-1:0] rd_addr;
  logic               rd_data_re;
  logic [COMP_W-1:0]  rd_data;
  logic               pix_valid_in;
  logic [INDEX_W-1:0] pix_index;
  logic               pix_valid_out;
  logic [OUT_W-1:0]   rgb_r;
  logic [OUT_W-1:0]   rgb_g;
  logic [OUT_W-1:0]   rgb_b;

  modport master (
    output wr_addr_we, wr_addr, wr_data_we, wr_data,
    output rd_addr_we, rd_addr, rd_data_re,
    output pix_valid_in, pix_index,
    input  rd_data, pix_valid_out, rgb_r, rgb_g, rgb_b
  );

  modport slave (
    input  wr_addr_we, wr_addr, wr_data_we, wr_data,
    input  rd_addr_we, rd_addr, rd_data_re,
    input  pix_valid_in, pix_index,
    output rd_data, pix_valid_out, rgb_r, rgb_g, rgb_b
  );
endinterface

// File: rtl/gpu_palette_clut.sv
// Parametrised colour lookup table: sequenced R/G/B CPU writes with atomic commit, 2-stage pixel lookup.
// Optional CPU readback port is enabled by defining GPU_PALETTE_READBACK_EN.
module gpu_palette_clut #(
  parameter int INDEX_W = 4,
  parameter int COMP_W  = 4,
  parameter int OUT_W   = 8
) (
  input logic              clk,
  input logic              rst_n,
  gpu_palette_clut_if.slave bus
);
  localparam int DEPTH = 1 << INDEX_W;
  localparam int ENT_W = 3 * COMP_W;

  typedef enum logic [1:0] {PH_R = 2'd0, PH_G = 2'd1, PH_B = 2'd2} phase_e;

  // Reset ramp value: replicate narrow indices, otherwise keep the index MSBs.
  function automatic logic [COMP_W-1:0] expComp(input logic [INDEX_W-1:0] idx);
    logic [COMP_W-1:0] r;
    int src;
    r = '0;
    for (int k = 0; k < COMP_W; k++) begin
      src = (INDEX_W < COMP_W) ? (INDEX_W - 1 - (k % INDEX_W)) : (INDEX_W - 1 - k);
      r[COMP_W-1-k] = idx[src];
    end
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] expOut(input logic [COMP_W-1:0] c);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int k = 0; k < OUT_W; k++) begin
      r[OUT_W-1-k] = c[COMP_W-1-(k % COMP_W)];
    end
    return r;
  endfunction

  logic [ENT_W-1:0]   mem_q [DEPTH];
  phase_e             wrPhase_q, wrPhase_d;
  logic [INDEX_W-1:0] wrIdx_q, wrIdx_d;
  logic [COMP_W-1:0]  stgR_q, stgR_d, stgG_q, stgG_d;
  logic               commitEn;

  always_ff @(posedge clk) begin
    if (!rst_n) wrPhase_q <= PH_R;
    else        wrPhase_q <= wrPhase_d;
  end

  always_comb begin
    wrPhase_d = wrPhase_q;
    if (bus.wr_addr_we) begin
      wrPhase_d = PH_R;
    end else if (bus.wr_data_we) begin
      case (wrPhase_q)
        PH_R:    wrPhase_d = PH_G;
        PH_G:    wrPhase_d = PH_B;
        default: wrPhase_d = PH_R;
      endcase
    end
  end

  // An address load wins over a same-cycle data write and drops any staged components.
  always_comb begin
    commitEn = 1'b0;
    wrIdx_d  = wrIdx_q;
    stgR_d   = stgR_q;
    stgG_d   = stgG_q;
    if (bus.wr_addr_we) begin
      wrIdx_d = bus.wr_addr;
      stgR_d  = '0;
      stgG_d  = '0;
    end else if (bus.wr_data_we) begin
      case (wrPhase_q)
        PH_R:    stgR_d = bus.wr_data;
        PH_G:    stgG_d = bus.wr_data;
        default: begin
          commitEn = 1'b1;
          wrIdx_d  = wrIdx_q + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrIdx_q <= '0;
      stgR_q  <= '0;
      stgG_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {3{expComp(INDEX_W'(i))}};
      end
    end else begin
      wrIdx_q <= wrIdx_d;
      stgR_q  <= stgR_d;
      stgG_q  <= stgG_d;
      if (commitEn) mem_q[wrIdx_q] <= {stgR_q, stgG_q, bus.wr_data};
    end
  end

  logic               s1Valid_q;
  logic [ENT_W-1:0]   s1Entry_q;
  logic               pixValid_q;
  logic [OUT_W-1:0]   rgbR_q, rgbG_q, rgbB_q;

  // Stage 1 samples the array before any same-cycle commit lands, so a collision sees the old entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1Valid_q  <= 1'b0;
      s1Entry_q  <= '0;
      pixValid_q <= 1'b0;
      rgbR_q     <= '0;
      rgbG_q     <= '0;
      rgbB_q     <= '0;
    end else begin
      s1Valid_q  <= bus.pix_valid_in;
      pixValid_q <= s1Valid_q;
      if (bus.pix_valid_in) s1Entry_q <= mem_q[bus.pix_index];
      if (s1Valid_q) begin
        rgbR_q <= expOut(s1Entry_q[ENT_W-1 -: COMP_W]);
        rgbG_q <= expOut(s1Entry_q[2*COMP_W-1 -: COMP_W]);
        rgbB_q <= expOut(s1Entry_q[COMP_W-1:0]);
      end
    end
  end

  assign bus.pix_valid_out = pixValid_q;
  assign bus.rgb_r         = rgbR_q;
  assign bus.rgb_g         = rgbG_q;
  assign bus.rgb_b         = rgbB_q;

`ifdef GPU_PALETTE_READBACK_EN
  phase_e             rdPhase_q, rdPhase_d;
  logic [INDEX_W-1:0] rdIdx_q, rdIdx_d;
  logic [COMP_W-1:0]  rdData_q, rdData_d;
  logic [ENT_W-1:0]   rdEntry;

  always_comb begin
    rdEntry   = mem_q[rdIdx_q];
    rdPhase_d = rdPhase_q;
    rdIdx_d   = rdIdx_q;
    rdData_d  = rdData_q;
    if (bus.rd_addr_we) begin
      rdIdx_d   = bus.rd_addr;
      rdPhase_d = PH_R;
    end else if (bus.rd_data_re) begin
      case (rdPhase_q)
        PH_R: begin
          rdData_d  = rdEntry[ENT_W-1 -: COMP_W];
          rdPhase_d = PH_G;
        end
        PH_G: begin
          rdData_d  = rdEntry[2*COMP_W-1 -: COMP_W];
          rdPhase_d = PH_B;
        end
        default: begin
          rdData_d  = rdEntry[COMP_W-1:0];
          rdPhase_d = PH_R;
          rdIdx_d   = rdIdx_q + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdPhase_q <= PH_R;
      rdIdx_q   <= '0;
      rdData_q  <= '0;
    end else begin
      rdPhase_q <= rdPhase_d;
      rdIdx_q   <= rdIdx_d;
      rdData_q  <= rdData_d;
    end
  end

  assign bus.rd_data = rdData_q;
`else
  logic unusedRd;
  assign unusedRd    = ^{bus.rd_addr_we, bus.rd_addr, bus.rd_data_re};
  assign bus.rd_data = '0;
`endif
endmodule

// File: tb/tb_gpu_palette_clut.sv
// Scoreboard bench for gpu_palette_clut: directed vectors push expectations, a negedge monitor pops them.
// Readback expectations follow GPU_PALETTE_READBACK_EN (zeros when the feature is compiled out).
module tb_gpu_palette_clut;
  localparam int INDEX_W = 4;
  localparam int COMP_W  = 4;
  localparam int OUT_W   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpu_palette_clut_if #(.INDEX_W(INDEX_W), .COMP_W(COMP_W), .OUT_W(OUT_W)) bus ();

  gpu_palette_clut #(.INDEX_W(INDEX_W), .COMP_W(COMP_W), .OUT_W(OUT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [23:0] rgb;
    int          due;
  } exp_t;

  exp_t       sbQ[$];
  logic [3:0] rdQ[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       rdPend = 1'b0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rdPend <= bus.rd_data_re & ~bus.rd_addr_we & rst_n;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every presented pixel or readback word must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.pix_valid_out === 1'b1) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_pixel", 32'd1, 32'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("pix_rgb", {8'h00, bus.rgb_r, bus.rgb_g, bus.rgb_b}, {8'h00, e.rgb});
          checkOutput("pix_latency", cyc, e.due);
        end
      end
      if (rdPend === 1'b1) begin
        if (rdQ.size() == 0) checkOutput("unexpected_rd", 32'd1, 32'd0);
        else                 checkOutput("rd_data", {28'd0, bus.rd_data}, {28'd0, rdQ.pop_front()});
      end
    end
  end

  task automatic idle();
    bus.wr_addr_we   = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data_we   = 1'b0;
    bus.wr_data      = '0;
    bus.rd_addr_we   = 1'b0;
    bus.rd_addr      = '0;
    bus.rd_data_re   = 1'b0;
    bus.pix_valid_in = 1'b0;
    bus.pix_index    = '0;
  endtask

  task automatic applyStimulus(input logic waWe, input logic [3:0] wa, input logic wdWe, input logic [3:0] wd,
                               input logic pv, input logic [3:0] pi, input logic [23:0] expRgb,
                               input logic raWe, input logic [3:0] ra, input logic re, input logic [3:0] expRd);
    bus.wr_addr_we   = waWe;
    bus.wr_addr      = wa;
    bus.wr_data_we   = wdWe;
    bus.wr_data      = wd;
    bus.pix_valid_in = pv;
    bus.pix_index    = pi;
    bus.rd_addr_we   = raWe;
    bus.rd_addr      = ra;
    bus.rd_data_re   = re;
    if (pv) sbQ.push_back('{rgb: expRgb, due: cyc + 2});
`ifdef GPU_PALETTE_READBACK_EN
    if (re && !raWe) rdQ.push_back(expRd);
`else
    if (re && !raWe) rdQ.push_back(4'h0);
`endif
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wrAddr(input logic [3:0] a);
    applyStimulus(1'b1, a, 1'b0, 4'h0, 1'b0, 4'h0, 24'h0, 1'b0, 4'h0, 1'b0, 4'h0);
  endtask

  task automatic wrData(input logic [3:0] d);
    applyStimulus(1'b0, 4'h0, 1'b1, d, 1'b0, 4'h0, 24'h0, 1'b0, 4'h0, 1'b0, 4'h0);
  endtask

  task automatic pix(input logic [3:0] i, input logic [23:0] e);
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, i, e, 1'b0, 4'h0, 1'b0, 4'h0);
  endtask

  task automatic rdRead(input logic [3:0] e);
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 24'h0, 1'b0, 4'h0, 1'b1, e);
  endtask

  // Bounded wait for the scoreboard to empty; an expired bound counts as a failed comparison.
  task automatic drain(input string name);
    for (int n = 0; n < 10 && (sbQ.size() != 0 || rdQ.size() != 0); n++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    checkOutput(name, sbQ.size() + rdQ.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] g;
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", {31'd0, bus.pix_valid_out}, 32'd0);
    checkOutput("reset_rgb_r", {24'd0, bus.rgb_r}, 32'd0);
    checkOutput("reset_rgb_g", {24'd0, bus.rgb_g}, 32'd0);
    checkOutput("reset_rgb_b", {24'd0, bus.rgb_b}, 32'd0);
    checkOutput("reset_rd_data", {28'd0, bus.rd_data}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] ramp lookups");
    pix(4'd5, 24'h555555);
    pix(4'd15, 24'hFFFFFF);
    drain("drain_ramp");
    checkOutput("rgb_hold", {8'h00, bus.rgb_r, bus.rgb_g, bus.rgb_b}, 32'h00FFFFFF);
    checkOutput("hold_valid", {31'd0, bus.pix_valid_out}, 32'd0);

    $display("[TB] auto-increment and wrap");
    wrAddr(4'd15);
    wrData(4'hA); wrData(4'h3); wrData(4'hC);
    wrData(4'h1); wrData(4'h2); wrData(4'h7);
    pix(4'd15, 24'hAA33CC);
    pix(4'd0, 24'h112277);
    pix(4'd1, 24'h111111);
    drain("drain_wrap");

    $display("[TB] atomic commit");
    wrAddr(4'd2);
    wrData(4'hF); wrData(4'hF);
    applyStimulus(1'b1, 4'd2, 1'b1, 4'h5, 1'b0, 4'h0, 24'h0, 1'b0, 4'h0, 1'b0, 4'h0);
    pix(4'd2, 24'h222222);
    wrData(4'h3); wrData(4'h4); wrData(4'h5);
    pix(4'd2, 24'h334455);
    drain("drain_atomic");

    $display("[TB] write/read collision");
    wrAddr(4'd4);
    wrData(4'h0); wrData(4'h0);
    applyStimulus(1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 4'd4, 24'h444444, 1'b0, 4'h0, 1'b0, 4'h0);
    pix(4'd4, 24'h000000);
    drain("drain_collision");

    $display("[TB] readback");
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 24'h0, 1'b1, 4'd15, 1'b0, 4'h0);
    rdRead(4'hA); rdRead(4'h3); rdRead(4'hC);
    rdRead(4'h1); rdRead(4'h2); rdRead(4'h7);
    drain("drain_readback");

    $display("[TB] back-to-back ramp after reset");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      g = {i[3:0], i[3:0]};
      pix(i[3:0], {g, g, g});
    end
    drain("drain_stream");

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 6; i++) begin
      g = {i[3:0], i[3:0]};
      pix(i[3:0], {g, g, g});
    end
    rst_n = 1'b0;
    bus.pix_valid_in = 1'b1;
    bus.pix_index    = 4'd6;
    @(posedge clk);
    #1;
    idle();
    sbQ.delete();
    checkOutput("flush_valid", {31'd0, bus.pix_valid_out}, 32'd0);
    checkOutput("flush_rgb_r", {24'd0, bus.rgb_r}, 32'd0);
    rst_n = 1'b1;
    pix(4'd15, 24'hFFFFFF);
    drain("drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
